tmr_ahb_mc: RTL and testbench

Multi-channel AHB-Lite timer: `ch_n` independent `tmr_w`-bit channels, each with an 8-bit prescaler and periodic, one-shot or input-capture mode. Per-channel interrupt status is gathered in a global W1C register and masked into a single `irq`. It sits on the peripheral AHB segment as a zero-wait-state slave. It supersedes the single-channel `tmr_ahb` for new SoC builds.

---
 rtl/tmr_ahb_mc.sv | 162 ++++++++++++++++
 tb/tb_tmr_ahb_mc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_ahb_mc.sv
// Multi-channel AHB-Lite timer: per-channel prescaler, periodic / one-shot / capture
// modes, W1C interrupt status gathered into a single masked irq.
module tmr_ahb_mc #(
  parameter int tmr_w = 16,
  parameter int ch_n  = 4
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic [7:0]      haddr,
  input  logic [31:0]     hwdata,
  output logic [31:0]     hrdata,
  input  logic            hwrite,
  input  logic [1:0]      htrans,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic            hsel,
  output logic            hready,
  output logic [1:0]      hresp,
  output logic            irq,
  input  logic [ch_n-1:0] tmr_in,
  output logic [ch_n-1:0] tmr_out
);

  // Handshake: a transfer is accepted whenever hsel && htrans != IDLE; the slave never
  // stalls (hready=1), so every accepted address phase is followed by exactly one data
  // phase in the next cycle, where writes commit on the closing edge and reads are driven.
  logic            dp_valid;
  logic            dp_write;
  logic [5:0]      dp_addr;
  logic [ch_n-1:0] irq_stat;
  logic [ch_n-1:0] irq_en;
  logic [ch_n-1:0] stat_set;
  logic            wr_en;
  logic            wr_stat;
  logic            wr_ien;
  logic [ch_n-1:0] wr_ctrl;
  logic [ch_n-1:0] wr_cnt;
  logic [ch_n-1:0] wr_cmp;
  logic [31:0]     ch_rd [ch_n];
  logic [31:0]     rd_val;
  logic            unused_bits;

  assign hready      = 1'b1;
  assign hresp       = 2'b00;
  assign unused_bits = ^{hsize, hburst, haddr[1:0], hwdata};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= hsel && (htrans != 2'b00);
      dp_write <= hwrite;
      dp_addr  <= haddr[7:2];
    end
  end

  always_comb begin
    wr_en   = dp_valid && dp_write;
    wr_stat = wr_en && (dp_addr == 6'd0);
    wr_ien  = wr_en && (dp_addr == 6'd1);
    for (int k = 0; k < ch_n; k++) begin
      wr_ctrl[k] = wr_en && (dp_addr[5:2] == 4'(k + 1)) && (dp_addr[1:0] == 2'd0);
      wr_cnt[k]  = wr_en && (dp_addr[5:2] == 4'(k + 1)) && (dp_addr[1:0] == 2'd1);
      wr_cmp[k]  = wr_en && (dp_addr[5:2] == 4'(k + 1)) && (dp_addr[1:0] == 2'd2);
    end
  end

  // Hardware set is OR-ed in after the W1C mask so a same-cycle set survives the clear.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      irq_stat <= '0;
      irq_en   <= '0;
    end else begin
      irq_stat <= (irq_stat & ~(wr_stat ? hwdata[ch_n-1:0] : '0)) | stat_set;
      if (wr_ien) irq_en <= hwdata[ch_n-1:0];
    end
  end

  assign irq = |(irq_stat & irq_en);

  for (genvar k = 0; k < ch_n; k++) begin : g_ch
    logic             en;
    logic [1:0]       mode;
    logic [7:0]       psc;
    logic [7:0]       pre;
    logic [tmr_w-1:0] cnt;
    logic [tmr_w-1:0] cmp;
    logic [tmr_w-1:0] cap;
    logic [2:0]       sync;
    logic             edge_r;
    logic             out;
    logic             tick;
    logic             hit;
    logic             match;
    logic             cap_evt;

    always_comb begin
      tick    = en && (pre == psc);
      hit     = tick && (mode != 2'b11) && !wr_cnt[k] && (cnt == cmp);
      match   = hit && (mode[1] == 1'b0);
      cap_evt = edge_r && en && (mode == 2'b10);
    end

    always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
        en     <= 1'b0;
        mode   <= 2'b00;
        psc    <= '0;
        pre    <= '0;
        cnt    <= '0;
        cmp    <= '0;
        cap    <= '0;
        sync   <= '0;
        edge_r <= 1'b0;
        out    <= 1'b0;
      end else begin
        if (!en || tick) pre <= '0;
        else             pre <= pre + 8'd1;
        // A bus write to CNT takes precedence and swallows any tick in the same cycle.
        if (wr_cnt[k])
          cnt <= hwdata[tmr_w-1:0];
        else if (tick && (mode != 2'b11))
          cnt <= (cnt == cmp) ? '0 : cnt + tmr_w'(1);
        if (wr_cmp[k]) cmp <= hwdata[tmr_w-1:0];
        // sync[1:0] is the synchroniser, sync[2] the previous sample for edge detection.
        sync   <= {sync[1:0], tmr_in[k]};
        edge_r <= sync[1] & ~sync[2];
        if (cap_evt) cap <= cnt;
        if (wr_ctrl[k]) begin
          en   <= hwdata[0];
          mode <= hwdata[2:1];
          psc  <= hwdata[15:8];
        end else if (match && (mode == 2'b01)) begin
          en <= 1'b0;
        end
        if (wr_ctrl[k] && (mode == 2'b01))      out <= 1'b0;
        else if (match && (mode == 2'b00))      out <= ~out;
        else if (match && (mode == 2'b01))      out <= 1'b1;
      end
    end

    assign stat_set[k] = match || cap_evt;
    assign tmr_out[k]  = out;
    assign ch_rd[k]    = (dp_addr[1:0] == 2'd0) ? {16'b0, psc, 5'b0, mode, en} :
                         (dp_addr[1:0] == 2'd1) ? 32'(cnt) :
                         (dp_addr[1:0] == 2'd2) ? 32'(cmp) : 32'(cap);
  end

  always_comb begin
    rd_val = '0;
    if (dp_addr == 6'd0) rd_val = 32'(irq_stat);
    if (dp_addr == 6'd1) rd_val = 32'(irq_en);
    for (int k = 0; k < ch_n; k++) begin
      if (dp_addr[5:2] == 4'(k + 1)) rd_val = ch_rd[k];
    end
  end

  assign hrdata = (dp_valid && !dp_write) ? rd_val : 32'd0;

endmodule

// File: tb/tb_tmr_ahb_mc.sv
// Directed bench for tmr_ahb_mc: reset, periodic, one-shot, capture, collisions, bus.
module tb_tmr_ahb_mc;
  logic        hclk = 1'b0;
  logic        hreset;
  logic [7:0]  haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hsel;
  logic        hready;
  logic [1:0]  hresp;
  logic        irq;
  logic [3:0]  tmr_in;
  logic [3:0]  tmr_out;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  tmr_ahb_mc #(.tmr_w(16), .ch_n(4)) dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hsel(hsel),
    .hready(hready), .hresp(hresp), .irq(irq), .tmr_in(tmr_in), .tmr_out(tmr_out)
  );

  // clock / watchdog
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: entered and left 1 time unit after a rising edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    haddr = a; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    @(posedge hclk); #1;
    hwdata = d; htrans = 2'b00; hsel = 1'b0; hwrite = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    haddr = a; hwrite = 1'b0; htrans = 2'b10; hsel = 1'b1;
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0;
    @(negedge hclk);
    d = hrdata;
    @(posedge hclk); #1;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    bus_read(a, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset = 1'b1; haddr = '0; hwdata = '0; hwrite = 1'b0; htrans = 2'b00;
    hsize = 3'b010; hburst = 3'b000; hsel = 1'b0; tmr_in = '0;
    wait_clk(3);
    hreset = 1'b0;

    // reset during a pending CMP0 write
    haddr = 8'h18; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    @(posedge hclk); #1;
    hwdata = 32'h1234; htrans = 2'b00; hsel = 1'b0; hwrite = 1'b0;
    #2 hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    check("rst_tmr_out", 32'(tmr_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_hready", 32'(hready), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata_idle", hrdata, 32'h0);
    read_check("rst_cmp0", 8'h18, 32'h0);
    read_check("rst_irq_stat", 8'h00, 32'h0);
    read_check("rst_irq_en", 8'h04, 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        read_check($sformatf("rst_ch%0d_reg%0d", k, j), 8'(8'h10 + 16 * k + 4 * j), 32'h0);
      end
    end

    // periodic ch0: CMP=4, PSC=1 -> match every 10 clocks, commit edge counted as P2
    bus_write(8'h04, 32'h1);
    bus_write(8'h18, 32'h4);
    bus_write(8'h10, 32'h0101);
    wait_clk(9);
    check("per_out_before_match", 32'(tmr_out[0]), 32'h0);
    check("per_irq_before_match", 32'(irq), 32'h0);
    wait_clk(1);
    check("per_out_first_match", 32'(tmr_out[0]), 32'h1);
    check("per_irq_first_match", 32'(irq), 32'h1);
    wait_clk(9);
    check("per_out_hold", 32'(tmr_out[0]), 32'h1);
    wait_clk(1);
    check("per_out_second_match", 32'(tmr_out[0]), 32'h0);
    bus_write(8'h00, 32'h1);
    check("per_irq_after_w1c", 32'(irq), 32'h0);
    read_check("per_stat_after_w1c", 8'h00, 32'h0);
    // W1C commit lands on the third match edge (P32): set wins
    wait_clk(4);
    bus_write(8'h00, 32'h1);
    check("col_w1c_irq", 32'(irq), 32'h1);
    check("col_w1c_out", 32'(tmr_out[0]), 32'h1);
    read_check("col_w1c_stat", 8'h00, 32'h1);
    // CNT0 write commits on a tick edge (P36): bus value wins
    bus_write(8'h14, 32'h20);
    read_check("col_cnt_write", 8'h14, 32'h20);
    bus_write(8'h10, 32'h0);
    bus_write(8'h00, 32'hF);
    read_check("stat_cleared", 8'h00, 32'h0);

    // one-shot ch1: CMP=3, PSC=0
    bus_write(8'h28, 32'h3);
    bus_write(8'h20, 32'h3);
    wait_clk(3);
    check("os_out_before", 32'(tmr_out[1]), 32'h0);
    wait_clk(1);
    check("os_out_fire", 32'(tmr_out[1]), 32'h1);
    read_check("os_ctrl_en_cleared", 8'h20, 32'h2);
    read_check("os_cnt_held", 8'h24, 32'h0);
    read_check("os_stat", 8'h00, 32'h2);
    bus_write(8'h20, 32'h3);
    check("os_out_cleared", 32'(tmr_out[1]), 32'h0);
    wait_clk(3);
    check("os_restart_before", 32'(tmr_out[1]), 32'h0);
    wait_clk(1);
    check("os_restart_fire", 32'(tmr_out[1]), 32'h1);

    // capture ch2: CNT starts at 97, reaches 100 three clocks after enabling
    bus_write(8'h38, 32'hFFFF);
    bus_write(8'h34, 32'd97);
    bus_write(8'h30, 32'h5);
    wait_clk(3);
    tmr_in = 4'b0100;
    wait_clk(4);
    tmr_in = 4'b0000;
    read_check("cap_value", 8'h3C, 32'd103);
    read_check("cap_stat", 8'h00, 32'h6);
    check("cap_irq_masked", 32'(irq), 32'h0);
    check("cap_out_held", 32'(tmr_out[2]), 32'h0);

    // bus: pipelined write then read of CMP3
    haddr = 8'h48; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    @(posedge hclk); #1;
    hwdata = 32'h0000ABCD; haddr = 8'h48; hwrite = 1'b0; htrans = 2'b10; hsel = 1'b1;
    @(negedge hclk);
    check("b2b_hrdata_write_phase", hrdata, 32'h0);
    check("b2b_hready", 32'(hready), 32'h1);
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0;
    @(negedge hclk);
    check("b2b_read_cmp3", hrdata, 32'h0000ABCD);
    @(posedge hclk); #1;
    read_check("unmapped_read", 8'h08, 32'h0);
    bus_write(8'h08, 32'hDEADBEEF);
    read_check("unmapped_write_dropped", 8'h08, 32'h0);
    bus_write(8'h48, 32'hFFFFFFFF);
    read_check("cmp3_width", 8'h48, 32'h0000FFFF);
    bus_write(8'h40, 32'hFFFFFFFE);
    read_check("ctrl3_fields", 8'h40, 32'h0000FF06);
    bus_write(8'h04, 32'hFFFFFFFF);
    read_check("irq_en_width", 8'h04, 32'h0000000F);
    check("irq_all_enabled", 32'(irq), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
